// File: rtl/add_sub_multicycle.sv
// Chunk-serial signed add/subtract unit: processes CHUNK bits per clock with a
// rippled carry between chunks, valid/ready handshake on both sides.
module add_sub_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_bad_params
    $error("add_sub_multicycle: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, bn_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               ovf_q;

  logic [CHUNK-1:0]   a_chk, b_chk, s_chk;
  logic               c_out;
  logic               last;
  logic               ovf_nxt;

  assign a_chk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chk = bn_q[idx_q*CHUNK +: CHUNK];
  assign {c_out, s_chk} = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry_q};
  assign last = (idx_q == IDX_W'(NCHUNK - 1));

  // Signed overflow from the top chunk: carry into MSB differs from carry out.
  assign ovf_nxt = a_q[WIDTH-1] ^ bn_q[WIDTH-1] ^ s_chk[CHUNK-1] ^ c_out;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a_q     <= '0;
      bn_q    <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      result  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_q     <= data_A;
          bn_q    <= data_B ^ {WIDTH{sub}};
          carry_q <= sub;
          idx_q   <= '0;
          result  <= '0;
          ovf_q   <= 1'b0;
        end
        BUSY: begin
          result[idx_q*CHUNK +: CHUNK] <= s_chk;
          carry_q <= c_out;
          idx_q   <= idx_q + 1'b1;
          if (last) ovf_q <= ovf_nxt;
        end
        default: ;
      endcase
    end
  end

  assign overflow   = ovf_q;
  assign isNotEqual = |result;
  assign isLessThan = result[WIDTH-1] ^ ovf_q;

endmodule
